// File: rtl/test_data_source.sv
// test_data_source: producer end of the test-data FIFO.
// When enabled, writes fixed-length bursts of generated words (incrementing counter or
// PRBS-16 LFSR) into the FIFO write port, starting a burst only when the registered
// write-side fill level leaves room for a whole burst.
//
// Ports:
//   clk           system clock, rising edge
//   RST           asynchronous active-high reset
//   enable        level; high permits bursts
//   mode          pattern select for the next burst: 0 = counter, 1 = LFSR
//   fifo_wrusedw  FIFO write-side used words
//   fifo_full     FIFO full flag; seen during a burst aborts it and sets ovf_err
//   fifo_wrreq    FIFO write request (registered)
//   fifo_data     FIFO write data (registered, aligned with fifo_wrreq)
//   busy          high while not idle
//   burst_cnt     completed bursts, wrapping
//   ovf_err       sticky overflow flag, cleared only by RST
module test_data_source #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BURST_LEN    = 1024,
  parameter int unsigned SPACE_THRESH = 2048
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              enable,
  input  logic              mode,
  input  logic [11:0]       fifo_wrusedw,
  input  logic              fifo_full,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              ovf_err
);

  localparam int unsigned     CntW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastWord = CntW'(BURST_LEN - 1);
  localparam logic [15:0]     LfsrSeed = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSpace,
    StWrite,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       wrusedw_q;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              wrreq_q, wrreq_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              ovf_q, ovf_d;

  logic              space_ok;
  logic              lfsr_fb;
  logic [DATA_W-1:0] lfsr_word;

  assign space_ok = 32'(wrusedw_q) <= SPACE_THRESH;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    lfsr_word       = '0;
    lfsr_word[15:0] = lfsr_q;
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    wrreq_d     = 1'b0;
    data_d      = data_q;
    burst_cnt_d = burst_cnt_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitSpace;
      end
      StWaitSpace: begin
        word_cnt_d = '0;
        if (!enable) begin
          state_d = StIdle;
        end else if (space_ok) begin
          state_d = StWrite;
          mode_d  = mode;
        end
      end
      StWrite: begin
        // Full wins over completion: an aborted burst is never counted
        if (fifo_full) begin
          state_d = StGap;
          ovf_d   = 1'b1;
        end else if (word_cnt_q == LastWord) begin
          state_d     = StGap;
          burst_cnt_d = burst_cnt_q + 16'd1;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      StGap: begin
        state_d = enable ? StWaitSpace : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Present the next word whenever the coming cycle is a write cycle; only the
    // selected generator advances.
    if (state_d == StWrite) begin
      wrreq_d = 1'b1;
      if (mode_d) begin
        data_d = lfsr_word;
        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
      end else begin
        data_d = cnt_q;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      wrusedw_q   <= '0;
      word_cnt_q  <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      lfsr_q      <= LfsrSeed;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      burst_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrusedw_q   <= fifo_wrusedw;
      word_cnt_q  <= word_cnt_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      burst_cnt_q <= burst_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign busy       = (state_q != StIdle);
  assign burst_cnt  = burst_cnt_q;
  assign ovf_err    = ovf_q;

endmodule

// File: doc/test_data_source.md
# test_data_source

Producer end of the test-data FIFO. When enabled, it writes fixed-length bursts of generated test words into the FIFO write port, and starts a burst only when the registered write-side fill level shows room for the whole burst. It sits in front of the FIFO whose read side is drained by the burst-read controller. It is the write-side counterpart of that controller and paces bursts on the FIFO fill level in the same way.

## Interface
Parameters:
- DATA_W, 16: width of generated words (LFSR mode requires DATA_W ≥ 16).
- BURST_LEN, 1024: words written per burst.
- SPACE_THRESH, 2048: a burst may start only if the registered wrusedw ≤ this value.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- enable  in  1  level; high permits bursts.
- mode  in  1  pattern select: 0 = incrementing counter, 1 = PRBS-16 LFSR.
- fifo_wrusedw  in  12  FIFO write-side used words.
- fifo_full  in  1  FIFO full flag.
- fifo_wrreq  out  1  FIFO write request, registered.
- fifo_data  out  DATA_W  FIFO write data, registered and aligned with fifo_wrreq.
- busy  out  1  high while the state is not IDLE.
- burst_cnt  out  16  number of completed bursts; wraps at 65535 → 0.
- ovf_err  out  1  sticky; set when fifo_full is seen during WRITE.

## Operation
- Input register: fifo_wrusedw_reg <= fifo_wrusedw every clk, under the same reset. All threshold decisions use the registered copy.
- State machine states: IDLE, WAIT_SPACE, WRITE, GAP.
  - IDLE: wrreq=0. If enable=1, go to WAIT_SPACE.
  - WAIT_SPACE: wrreq=0, word count=0.
    - If enable=0, go to IDLE.
    - Else if fifo_wrusedw_reg ≤ SPACE_THRESH, go to WRITE and latch mode into mode_q.
  - WRITE: wrreq=1, fifo_data = current pattern word, pattern advances one step per written word.
    - Word count 0..BURST_LEN-1. On word BURST_LEN-1, go to GAP and increment burst_cnt.
    - enable falling during WRITE does not cut the burst short.
  - GAP: wrreq=0 for exactly one cycle. Then go to WAIT_SPACE if enable=1, else IDLE.
- Overflow: if fifo_full=1 is sampled while in WRITE:
  - next cycle wrreq=0 and ovf_err<=1;
  - burst_cnt is not incremented;
  - state goes to GAP, i.e. the burst is aborted.
  - ovf_err clears only on RST.
- Patterns:
  - Each generator keeps its own state, which persists across bursts and across enable toggles and is cleared only by RST.
  - Counter mode: starts at 0 and increments by 1 per word, modulo 2^DATA_W.
  - LFSR mode: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1. Output is the LFSR value zero-extended to DATA_W, and the LFSR shifts once per word. It never reaches all-zero.
  - mode changes take effect only at the next burst start.
- Only the selected generator advances.

## Timing
- Reset values:
  - fifo_wrreq = 0, fifo_data = 0, busy = 0, burst_cnt = 0, ovf_err = 0;
  - state = IDLE, word count = 0, counter = 0, LFSR = 16'hACE1, fifo_wrusedw_reg = 0.
- Reset mid-burst: wrreq drops asynchronously with RST. Nothing resumes after release.
- Start latency: with enable=1 in WAIT_SPACE, fifo_wrreq rises on the 2nd rising edge after fifo_wrusedw first meets the threshold (1 edge to register the input, 1 edge for the decision).
- Burst shape:
  - exactly BURST_LEN consecutive cycles of wrreq=1, no holes;
  - then at least one wrreq=0 GAP cycle;
  - then at least one WAIT_SPACE cycle before the next burst.
  - Minimum period is BURST_LEN+2 cycles.
- burst_cnt updates on the same edge that drops wrreq after a complete burst.
- Full detection latency: one word may be presented in the cycle fifo_full rises, and is dropped by the FIFO. wrreq is low by the following edge.
- Boundaries:
  - fifo_wrusedw_reg = SPACE_THRESH starts a burst; SPACE_THRESH+1 does not.
  - enable=0 sampled in GAP returns to IDLE.

## Test plan
- Reset then enable=1, mode=0, fifo_wrusedw=0 held → wrreq high 1024 cycles with data 0..1023, one GAP cycle, one WAIT_SPACE cycle, next burst data 1024..2047; burst_cnt=2 after that burst.
- mode=1, wrusedw=0 → first burst first words 16'hACE1, then successive LFSR states; a second burst continues the sequence with no reseed.
- wrusedw=2049 for 50 cycles then 2048 → no wrreq while at 2049; wrreq rises 2 edges after 2048 is applied.
- Raise fifo_full at word 500 of a burst → wrreq low the next cycle, ovf_err=1, burst_cnt unchanged; ovf_err stays 1 through later bursts until RST.
- Drop enable at word 10 of a burst → all 1024 words are still written, then GAP, then IDLE with busy=0 and no further wrreq.
- Assert RST at word 300 → all outputs at reset values immediately; after release with enable=1, the first burst data restarts at 0.
